// File: rtl/mario_pkg.sv
// ---------------------------------------------------------------------------
// mario_pkg
// Shared sprite constants and types for the Mario sprite blocks.
//   - mush_state_e : life cycle of a power-up mushroom
//   - dir_e        : horizontal walking direction
//   - MUSH_SIZE, MARIO_W, MARIO_H_SMALL, MARIO_H_BIG : sprite sizes in pixels,
//     11 bits wide so they add straight onto a zero-extended 10-bit coordinate
//   - mario_height() : Mario's height for a given size flag
// ---------------------------------------------------------------------------
package mario_pkg;

    typedef enum logic [1:0] {
        ST_HIDDEN   = 2'd0,
        ST_EMERGING = 2'd1,
        ST_MOVING   = 2'd2,
        ST_CONSUMED = 2'd3
    } mush_state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    localparam logic [10:0] MUSH_SIZE     = 11'd16;
    localparam logic [10:0] MARIO_W       = 11'd16;
    localparam logic [10:0] MARIO_H_SMALL = 11'd16;
    localparam logic [10:0] MARIO_H_BIG   = 11'd32;

    // Big Mario is twice as tall as small Mario; width never changes.
    function automatic logic [10:0] mario_height(input logic is_big);
        logic [10:0] h;
        if (is_big) begin
            h = MARIO_H_BIG;
        end else begin
            h = MARIO_H_SMALL;
        end
        return h;
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// ---------------------------------------------------------------------------
// aabb_overlap
// Combinational axis-aligned box overlap test, shared by sprite blocks.
// Boxes are half-open: [x, x+w) x [y, y+h). Sums are taken one bit wider than
// the coordinates so nothing wraps near the screen edge.
// Ports:
//   a_x, a_y : box A top-left corner (W bits)
//   a_w, a_h : box A size (W+1 bits)
//   b_x, b_y : box B top-left corner (W bits)
//   b_w, b_h : box B size (W+1 bits)
//   hit      : 1 when the two boxes share at least one pixel
// ---------------------------------------------------------------------------
module aabb_overlap #(
    parameter int unsigned W = 32'd10
) (
    input  logic [W-1:0] a_x,
    input  logic [W-1:0] a_y,
    input  logic [W:0]   a_w,
    input  logic [W:0]   a_h,
    input  logic [W-1:0] b_x,
    input  logic [W-1:0] b_y,
    input  logic [W:0]   b_w,
    input  logic [W:0]   b_h,
    output logic         hit
);

    logic [W:0] a_x_s;
    logic [W:0] a_y_s;
    logic [W:0] b_x_s;
    logic [W:0] b_y_s;
    logic [W:0] a_x_end_s;
    logic [W:0] a_y_end_s;
    logic [W:0] b_x_end_s;
    logic [W:0] b_y_end_s;

    assign a_x_s     = {1'b0, a_x};
    assign a_y_s     = {1'b0, a_y};
    assign b_x_s     = {1'b0, b_x};
    assign b_y_s     = {1'b0, b_y};
    assign a_x_end_s = a_x_s + a_w;
    assign a_y_end_s = a_y_s + a_h;
    assign b_x_end_s = b_x_s + b_w;
    assign b_y_end_s = b_y_s + b_h;

    // Each box must start before the other one ends, on both axes.
    assign hit = (a_x_s < b_x_end_s) && (b_x_s < a_x_end_s) &&
                 (a_y_s < b_y_end_s) && (b_y_s < a_y_end_s);

endmodule

// File: rtl/mushroom_pickup.sv
// ---------------------------------------------------------------------------
// mushroom_pickup
// Power-up mushroom: spawns from a question block when Mario bumps it, rises
// out of the block over EMERGE_FRAMES frames, walks left/right bouncing off
// the screen edges, and is consumed (one collision pulse) when Mario touches
// it. Consumption is terminal until Reset.
// Ports:
//   Clk          : clock
//   Reset        : synchronous, active-high
//   frame_tick   : one-Clk pulse per video frame, paces all movement
//   block_hit    : Mario bumped the block (only honoured while hidden)
//   mario_x/y    : Mario top-left corner
//   superMario   : 0 = 16x16 Mario, 1 = 16x32 Mario
//   collision    : one-Clk pickup pulse, one Clk after the first overlap
//   mush_visible : mushroom should be drawn
//   mush_x/y     : mushroom top-left corner
// ---------------------------------------------------------------------------
module mushroom_pickup
    import mario_pkg::*;
#(
    parameter logic [9:0]  BLOCK_X       = 10'd200,
    parameter logic [9:0]  BLOCK_Y       = 10'd300,
    parameter int unsigned EMERGE_FRAMES = 32'd16,
    parameter int unsigned SPEED         = 32'd1,
    parameter logic [9:0]  SCREEN_MAX_X  = 10'd639
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       block_hit,
    input  logic [9:0] mario_x,
    input  logic [9:0] mario_y,
    input  logic       superMario,
    output logic       collision,
    output logic       mush_visible,
    output logic [9:0] mush_x,
    output logic [9:0] mush_y
);

    localparam int unsigned     CNT_W      = $clog2(EMERGE_FRAMES + 32'd1);
    localparam logic [CNT_W-1:0] EMERGE_CNT = CNT_W'(EMERGE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    localparam logic [10:0]     SPEED_X    = 11'(SPEED);
    // Rightmost legal left edge keeps the whole 16-pixel sprite on screen.
    localparam logic [10:0]     X_LIMIT    = {1'b0, SCREEN_MAX_X} - 11'd15;

    mush_state_e      state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             collision_q, collision_d;
    logic             visible_q, visible_d;

    logic             hit_s;
    logic             overlap_s;
    logic [10:0]      x_right_s;
    logic [10:0]      x_left_s;
    logic [CNT_W-1:0] cnt_inc_s;

    aabb_overlap #(
        .W(32'd10)
    ) u_overlap (
        .a_x (mario_x),
        .a_y (mario_y),
        .a_w (MARIO_W),
        .a_h (mario_height(superMario)),
        .b_x (x_q),
        .b_y (y_q),
        .b_w (MUSH_SIZE),
        .b_h (MUSH_SIZE),
        .hit (hit_s)
    );

    // Pickup is only possible while the mushroom is walking.
    assign overlap_s = hit_s && (state_q == ST_MOVING);

    // Candidate positions in 11 bits: bit 10 of x_left_s flags an underflow.
    assign x_right_s = {1'b0, x_q} + SPEED_X;
    assign x_left_s  = {1'b0, x_q} - SPEED_X;
    assign cnt_inc_s = cnt_q + CNT_ONE;

    // Next-state, motion and pickup logic.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        collision_d = 1'b0;

        case (state_q)
            ST_HIDDEN: begin
                if (block_hit) begin
                    state_d = ST_EMERGING;
                    x_d     = BLOCK_X;
                    y_d     = BLOCK_Y;
                    cnt_d   = '0;
                    dir_d   = DIR_RIGHT;
                end else begin
                    state_d = ST_HIDDEN;
                end
            end

            ST_EMERGING: begin
                if (frame_tick) begin
                    y_d   = y_q - 10'd1;
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == EMERGE_CNT) begin
                        state_d = ST_MOVING;
                    end else begin
                        state_d = ST_EMERGING;
                    end
                end else begin
                    state_d = ST_EMERGING;
                end
            end

            ST_MOVING: begin
                // A touch on a tick frame is consumed before the step is taken.
                if (overlap_s) begin
                    state_d     = ST_CONSUMED;
                    collision_d = 1'b1;
                end else if (frame_tick) begin
                    if (dir_q == DIR_RIGHT) begin
                        if (x_right_s > X_LIMIT) begin
                            x_d   = X_LIMIT[9:0];
                            dir_d = DIR_LEFT;
                        end else begin
                            x_d = x_right_s[9:0];
                        end
                    end else begin
                        if (x_left_s[10]) begin
                            x_d   = 10'd0;
                            dir_d = DIR_RIGHT;
                        end else begin
                            x_d = x_left_s[9:0];
                        end
                    end
                end else begin
                    state_d = ST_MOVING;
                end
            end

            ST_CONSUMED: begin
                state_d = ST_CONSUMED;
            end

            default: begin
                state_d = ST_HIDDEN;
            end
        endcase

        visible_d = (state_d == ST_EMERGING) || (state_d == ST_MOVING);
    end

    // State and output registers; Reset overrides everything, including a
    // pending pickup, so no pulse can escape after a reset edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_HIDDEN;
            dir_q       <= DIR_RIGHT;
            x_q         <= BLOCK_X;
            y_q         <= BLOCK_Y;
            cnt_q       <= '0;
            collision_q <= 1'b0;
            visible_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
            visible_q   <= visible_d;
        end
    end

    assign collision    = collision_q;
    assign mush_visible = visible_q;
    assign mush_x       = x_q;
    assign mush_y       = y_q;

endmodule

// File: tb/tb_mushroom_pickup.sv
module tb_mushroom_pickup;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       block_hit = 1'b0;
    logic [9:0] mario_x = 10'd0;
    logic [9:0] mario_y = 10'd0;
    logic       superMario = 1'b0;
    logic       collision;
    logic       mush_visible;
    logic [9:0] mush_x;
    logic [9:0] mush_y;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    mushroom_pickup dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .block_hit    (block_hit),
        .mario_x      (mario_x),
        .mario_y      (mario_y),
        .superMario   (superMario),
        .collision    (collision),
        .mush_visible (mush_visible),
        .mush_x       (mush_x),
        .mush_y       (mush_y)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic spawn();
        block_hit = 1'b1;
        step();
        block_hit = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_collision", 32'(collision), 32'd0);
        chk("rst_visible", 32'(mush_visible), 32'd0);
        chk("rst_x", 32'(mush_x), 32'd200);
        chk("rst_y", 32'(mush_y), 32'd300);
        Reset = 1'b0;

        // ticks while hidden do nothing
        tick_n(3);
        chk("hidden_y", 32'(mush_y), 32'd300);
        chk("hidden_visible", 32'(mush_visible), 32'd0);

        // ---------------- spawn + emerge, block_hit held afterwards --------
        spawn();
        chk("spawn_visible", 32'(mush_visible), 32'd1);
        chk("spawn_x", 32'(mush_x), 32'd200);
        chk("spawn_y", 32'(mush_y), 32'd300);
        block_hit = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick_n(1);
            chk("emerge_y", 32'(mush_y), 32'(300 - i));
            if (i == 3) begin
                step();
                chk("emerge_idle_y", 32'(mush_y), 32'd297);
            end
        end
        chk("emerged_visible", 32'(mush_visible), 32'd1);
        chk("emerged_x", 32'(mush_x), 32'd200);
        // first walking tick proves the block is in MOVING
        tick_n(1);
        chk("move_x_201", 32'(mush_x), 32'd201);
        chk("move_y_fixed", 32'(mush_y), 32'd284);

        // ---------------- right wall ----------------
        tick_n(421);
        chk("walk_x_622", 32'(mush_x), 32'd622);
        tick_n(1);
        chk("wall_x_623", 32'(mush_x), 32'd623);
        tick_n(1);
        chk("wall_x_624", 32'(mush_x), 32'd624);
        tick_n(1);
        chk("wall_clamp_624", 32'(mush_x), 32'd624);
        tick_n(1);
        chk("wall_back_623", 32'(mush_x), 32'd623);
        tick_n(1);
        chk("wall_back_622", 32'(mush_x), 32'd622);
        chk("wall_y_fixed", 32'(mush_y), 32'd284);
        chk("wall_visible", 32'(mush_visible), 32'd1);

        // ---------------- pickup at (200,284), small Mario ----------------
        tick_n(422);
        chk("return_x_200", 32'(mush_x), 32'd200);
        mario_x    = 10'd210;
        mario_y    = 10'd284;
        superMario = 1'b0;
        frame_tick = 1'b1;   // same-cycle tick must lose to the pickup
        step();
        frame_tick = 1'b0;
        chk("pickup_pulse", 32'(collision), 32'd1);
        chk("pickup_hidden", 32'(mush_visible), 32'd0);
        chk("pickup_x_frozen", 32'(mush_x), 32'd200);
        step();
        chk("pickup_pulse_end", 32'(collision), 32'd0);
        for (int i = 0; i < 100; i++) begin
            if (i % 10 == 0) frame_tick = 1'b1;
            else frame_tick = 1'b0;
            step();
            chk("post_pickup_quiet", 32'(collision), 32'd0);
        end
        frame_tick = 1'b0;
        chk("consumed_no_respawn", 32'(mush_visible), 32'd0);
        block_hit = 1'b0;

        // ---------------- big-Mario height case ----------------
        do_reset();
        chk("rst2_visible", 32'(mush_visible), 32'd0);
        mario_x = 10'd200;
        mario_y = 10'd300;   // sits on the mushroom, ignored while emerging
        spawn();
        for (int i = 0; i < 15; i++) begin
            tick_n(1);
            chk("emerge_no_pickup", 32'(collision), 32'd0);
        end
        chk("emerge_still_visible", 32'(mush_visible), 32'd1);
        mario_y    = 10'd254;
        superMario = 1'b0;
        tick_n(1);
        chk("big_case_y", 32'(mush_y), 32'd284);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("small_no_pulse", 32'(collision), 32'd0);
        end
        chk("small_still_visible", 32'(mush_visible), 32'd1);
        superMario = 1'b1;
        step();
        chk("big_pulse", 32'(collision), 32'd1);
        step();
        chk("big_pulse_end", 32'(collision), 32'd0);
        chk("big_consumed", 32'(mush_visible), 32'd0);

        // ---------------- left wall, then reset racing a pickup ----------------
        superMario = 1'b0;
        mario_x    = 10'd0;
        mario_y    = 10'd0;
        do_reset();
        spawn();
        tick_n(16);
        tick_n(424);
        chk("run3_x_624", 32'(mush_x), 32'd624);
        tick_n(1);
        chk("run3_clamp_624", 32'(mush_x), 32'd624);
        tick_n(623);
        chk("left_x_1", 32'(mush_x), 32'd1);
        tick_n(1);
        chk("left_x_0", 32'(mush_x), 32'd0);
        tick_n(1);
        chk("left_clamp_0", 32'(mush_x), 32'd0);
        tick_n(1);
        chk("left_back_1", 32'(mush_x), 32'd1);
        mario_x = 10'd5;
        mario_y = 10'd284;
        Reset   = 1'b1;
        step();
        chk("race_collision", 32'(collision), 32'd0);
        chk("race_visible", 32'(mush_visible), 32'd0);
        chk("race_x", 32'(mush_x), 32'd200);
        chk("race_y", 32'(mush_y), 32'd300);
        Reset = 1'b0;
        step();
        chk("race_collision_after", 32'(collision), 32'd0);
        chk("race_still_hidden", 32'(mush_visible), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
